// File: rtl/axis_adder_arbiter.sv
// axis_adder_arbiter: round-robin arbiter that time-shares one two-operand
// adder among NUM_PORTS AXI4-Stream requesters, with optional burst hold.
// The result register is tagged in tuser with the originating port index.
// Optional feature macro: AXIS_ADDER_ARBITER_SATURATE_EN (saturating sum
// instead of modular wrap; latency unchanged).
module axis_adder_arbiter #(
    parameter int    NUM_PORTS         = 4,
    parameter int    AXIS_TDATA_WIDTH  = 32,
    parameter string AXIS_TDATA_SIGNED = "FALSE",
    parameter int    BURST_LEN         = 1,
    localparam int   UW                = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                    aclk,
    input  logic                                    areset,
    input  logic [NUM_PORTS*2*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                    s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                    s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic [UW-1:0]                           m_axis_tuser,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready
);

    localparam int              W          = AXIS_TDATA_WIDTH;
    localparam bit              IS_SIGNED  = (AXIS_TDATA_SIGNED == "TRUE");
    localparam logic [0:0]      ST_ARB     = 1'b0;
    localparam logic [0:0]      ST_HOLD    = 1'b1;
    localparam logic [7:0]      BURST_LAST = 8'(BURST_LEN);
    localparam logic [UW-1:0]   LAST_PORT  = UW'(NUM_PORTS - 1);

    // Control state
    logic [0:0]           r_state;
    logic [UW-1:0]        r_rr_ptr;
    logic [UW-1:0]        r_held;
    logic [7:0]           r_beat_cnt;

    // Output stage
    logic                 r_vld_p1;
    logic signed [W-1:0]  r_tdata_p1;
    logic [UW-1:0]        r_tuser_p1;

    // Arbitration and datapath
    logic                 w_can_accept;
    logic                 w_found;
    logic [UW-1:0]        w_grant;
    logic                 w_found_hi;
    logic [UW-1:0]        w_grant_hi;
    logic [UW-1:0]        w_sel;
    logic                 w_held_vld;
    logic [NUM_PORTS-1:0] w_ready;
    logic                 w_xfer;
    logic signed [W-1:0]  w_op_a_p0;
    logic signed [W-1:0]  w_op_b_p0;
    logic signed [W-1:0]  w_sum_p0;

    // Round-robin successor with wrap at NUM_PORTS (not necessarily a power of two).
    function automatic logic [UW-1:0] f_next(input logic [UW-1:0] p);
        return (p == LAST_PORT) ? '0 : p + UW'(1);
    endfunction

    // W+1-bit add with sign/zero extension; either clamp or wrap back to W bits.
    function automatic logic signed [W-1:0] f_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [W:0] ext_sum;
        if (IS_SIGNED)
            ext_sum = {a[W-1], a} + {b[W-1], b};
        else
            ext_sum = {1'b0, a} + {1'b0, b};
`ifdef AXIS_ADDER_ARBITER_SATURATE_EN
        if (IS_SIGNED) begin
            // Top two bits disagree only when the true sum left the W-bit range.
            if (ext_sum[W] != ext_sum[W-1])
                return ext_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            return W'(ext_sum);
        end
        return ext_sum[W] ? '1 : W'(ext_sum);
`else
        return W'(ext_sum);
`endif
    endfunction

    assign w_can_accept = ~r_vld_p1 | m_axis_tready;

    // Grant: lowest valid index at or above rr_ptr, else lowest valid index overall (wrap).
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_found_hi = 1'b0;
        w_grant_hi = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                w_found = 1'b1;
                w_grant = UW'(i);
                if (UW'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_grant_hi = UW'(i);
                end
            end
        end
        if (w_found_hi)
            w_grant = w_grant_hi;
    end

    // Ready generation: one-hot on the selected port, suppressed during reset and backpressure.
    always_comb begin
        w_ready    = '0;
        w_held_vld = 1'b0;
        w_sel      = (r_state == ST_HOLD) ? r_held : w_grant;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (UW'(i) == r_held)
                w_held_vld = s_axis_tvalid[i];
            if (UW'(i) == w_sel) begin
                if (r_state == ST_HOLD)
                    w_ready[i] = w_can_accept & s_axis_tvalid[i];
                else
                    w_ready[i] = w_can_accept & w_found;
            end
        end
        if (areset)
            w_ready = '0;
    end

    assign w_xfer = |w_ready;

    // Operand mux: pick the selected port's (a, b) pair for the shared adder.
    always_comb begin
        w_op_a_p0 = '0;
        w_op_b_p0 = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (UW'(i) == w_sel) begin
                w_op_a_p0 = s_axis_tdata[2*i*W +: W];
                w_op_b_p0 = s_axis_tdata[(2*i+1)*W +: W];
            end
        end
    end

    assign w_sum_p0 = f_add(w_op_a_p0, w_op_b_p0);

    // Output register: load on transfer, drop valid when downstream takes the beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_vld_p1   <= 1'b0;
            r_tdata_p1 <= '0;
            r_tuser_p1 <= '0;
        end else if (w_xfer) begin
            r_vld_p1   <= 1'b1;
            r_tdata_p1 <= w_sum_p0;
            r_tuser_p1 <= w_sel;
        end else if (m_axis_tready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    // Arbitration FSM: rotate after each beat, or hold a port for up to BURST_LEN beats.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_held     <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_xfer) begin
                        if (BURST_LEN == 1) begin
                            r_rr_ptr <= f_next(w_grant);
                        end else begin
                            r_state    <= ST_HOLD;
                            r_held     <= w_grant;
                            r_beat_cnt <= 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        if (r_beat_cnt + 8'd1 == BURST_LAST) begin
                            r_state    <= ST_ARB;
                            r_rr_ptr   <= f_next(r_held);
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end else if (w_can_accept && !w_held_vld) begin
                        // Held port went idle: give up the burst early.
                        r_state    <= ST_ARB;
                        r_rr_ptr   <= f_next(r_held);
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tdata  = r_tdata_p1;
    assign m_axis_tuser  = r_tuser_p1;
    assign m_axis_tvalid = r_vld_p1;

endmodule

// File: tb/tb_axis_adder_arbiter.sv
// Directed testbench for axis_adder_arbiter (NUM_PORTS=4, W=16).
// Three instances share stimulus: unsigned BURST_LEN=2, unsigned BURST_LEN=1,
// signed BURST_LEN=2. Expected sums follow AXIS_ADDER_ARBITER_SATURATE_EN.
module tb_axis_adder_arbiter;

    logic         aclk;
    logic         areset;
    logic [127:0] s_tdata;
    logic [3:0]   s_tvalid;
    logic         m_tready;

    logic [3:0]   rdy0, rdy1, rdys;
    logic [15:0]  td0, td1, tds;
    logic [1:0]   tu0, tu1, tus;
    logic         tv0, tv1, tvs;

    int checks;
    int failures;

    axis_adder_arbiter #(.NUM_PORTS(4), .AXIS_TDATA_WIDTH(16), .AXIS_TDATA_SIGNED("FALSE"), .BURST_LEN(2)) dut (
        .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(rdy0), .m_axis_tdata(td0), .m_axis_tuser(tu0), .m_axis_tvalid(tv0),
        .m_axis_tready(m_tready));

    axis_adder_arbiter #(.NUM_PORTS(4), .AXIS_TDATA_WIDTH(16), .AXIS_TDATA_SIGNED("FALSE"), .BURST_LEN(1)) dut1 (
        .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(rdy1), .m_axis_tdata(td1), .m_axis_tuser(tu1), .m_axis_tvalid(tv1),
        .m_axis_tready(m_tready));

    axis_adder_arbiter #(.NUM_PORTS(4), .AXIS_TDATA_WIDTH(16), .AXIS_TDATA_SIGNED("TRUE"), .BURST_LEN(2)) dut_s (
        .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(rdys), .m_axis_tdata(tds), .m_axis_tuser(tus), .m_axis_tvalid(tvs),
        .m_axis_tready(m_tready));

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [15:0] a, input logic [15:0] b);
        s_tdata[2*p*16 +: 16]     = a;
        s_tdata[(2*p+1)*16 +: 16] = b;
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        s_tvalid = 4'b0000;
        m_tready = 1'b1;
        step();
        chk("rst_tvalid", 32'(tv0), 32'h0);
        chk("rst_ready", 32'(rdy0), 32'h0);
        areset = 1'b0;
    endtask

    logic [1:0]  seq2 [10];
    logic [15:0] sums [4];
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] exps [3];
    logic [15:0] expu [3];

    initial begin
        checks   = 0;
        failures = 0;
        seq2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        sums = '{16'h0011, 16'h1022, 16'h2033, 16'h3044};
        va   = '{16'h7FFF, 16'h8000, 16'hFFFF};
        vb   = '{16'h0001, 16'hFFFF, 16'h0002};
`ifdef AXIS_ADDER_ARBITER_SATURATE_EN
        exps = '{16'h7FFF, 16'h8000, 16'h0001};
        expu = '{16'h8000, 16'hFFFF, 16'hFFFF};
`else
        exps = '{16'h8000, 16'h7FFF, 16'h0001};
        expu = '{16'h8000, 16'h7FFF, 16'h0001};
`endif

        // Reset with every port valid and downstream ready
        areset   = 1'b1;
        m_tready = 1'b1;
        s_tdata  = '0;
        set_port(0, 16'h0000, 16'h0011);
        set_port(1, 16'h1000, 16'h0022);
        set_port(2, 16'h2000, 16'h0033);
        set_port(3, 16'h3000, 16'h0044);
        s_tvalid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("reset_ready", 32'(rdy0), 32'h0);
            chk("reset_ready_bl1", 32'(rdy1), 32'h0);
            chk("reset_tvalid", 32'(tv0), 32'h0);
            chk("reset_tdata", 32'(td0), 32'h0);
            chk("reset_tuser", 32'(tu0), 32'h0);
        end
        areset = 1'b0;
        #1;
        chk("first_grant", 32'(rdy0), 32'h1);
        chk("first_grant_bl1", 32'(rdy1), 32'h1);
        chk("first_grant_sgn", 32'(rdys), 32'h1);

        // All ports continuously valid: burst-2 and burst-1 rotation
        for (int c = 0; c < 10; c++) begin
            step();
            chk("rr_bl2_tuser", 32'(tu0), 32'(seq2[c]));
            chk("rr_bl2_tvalid", 32'(tv0), 32'h1);
            chk("rr_bl2_tdata", 32'(td0), 32'(sums[seq2[c]]));
            chk("rr_bl1_tuser", 32'(tu1), 32'(c % 4));
        end

        // Single port 2 request
        do_reset();
        set_port(2, 16'd3, 16'd5);
        s_tvalid = 4'b0100;
        #1;
        chk("p2_ready", 32'(rdy0), 32'h4);
        step();
        chk("p2_tdata", 32'(td0), 32'd8);
        chk("p2_tuser", 32'(tu0), 32'd2);
        chk("p2_tvalid", 32'(tv0), 32'h1);
        s_tvalid = 4'b0000;
        #1;
        chk("idle_ready", 32'(rdy0), 32'h0);
        step();
        chk("idle_tvalid", 32'(tv0), 32'h0);
        chk("idle_tdata_hold", 32'(td0), 32'd8);

        // Backpressure: output pending with tready low for 5 cycles
        do_reset();
        set_port(0, 16'h0001, 16'h0002);
        set_port(1, 16'h0010, 16'h0020);
        s_tvalid = 4'b0011;
        m_tready = 1'b0;
        #1;
        chk("bp_first_ready", 32'(rdy0), 32'h1);
        step();
        chk("bp_tvalid", 32'(tv0), 32'h1);
        chk("bp_tdata", 32'(td0), 32'h3);
        chk("bp_tuser", 32'(tu0), 32'h0);
        set_port(0, 16'h0005, 16'h0005);
        for (int k = 0; k < 5; k++) begin
            chk("bp_stall_ready", 32'(rdy0), 32'h0);
            step();
            chk("bp_stall_tvalid", 32'(tv0), 32'h1);
            chk("bp_stall_tdata", 32'(td0), 32'h3);
            chk("bp_stall_tuser", 32'(tu0), 32'h0);
        end
        m_tready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(rdy0), 32'h1);
        step();
        chk("bp_beat2_tdata", 32'(td0), 32'h000A);
        chk("bp_beat2_tuser", 32'(tu0), 32'h0);
        chk("bp_beat2_tvalid", 32'(tv0), 32'h1);
        #1;
        chk("bp_rotate_ready", 32'(rdy0), 32'h2);
        step();
        chk("bp_beat3_tdata", 32'(td0), 32'h0030);
        chk("bp_beat3_tuser", 32'(tu0), 32'h1);
        s_tvalid = 4'b0000;
        step();
        chk("bp_drain_tvalid", 32'(tv0), 32'h0);

        // Overflow behaviour, signed and unsigned
        do_reset();
        s_tvalid = 4'b0001;
        for (int v = 0; v < 3; v++) begin
            set_port(0, va[v], vb[v]);
            step();
            chk("arith_signed", 32'(tds), 32'(exps[v]));
            chk("arith_signed_vld", 32'(tvs), 32'h1);
            chk("arith_unsigned", 32'(td0), 32'(expu[v]));
            chk("arith_unsigned_bl1", 32'(td1), 32'(expu[v]));
        end

        // Held port drops valid after one beat
        do_reset();
        set_port(1, 16'd1, 16'd1);
        set_port(3, 16'd2, 16'd2);
        s_tvalid = 4'b0010;
        #1;
        chk("hold_p1_ready", 32'(rdy0), 32'h2);
        step();
        chk("hold_p1_tuser", 32'(tu0), 32'h1);
        chk("hold_p1_tdata", 32'(td0), 32'h2);
        s_tvalid = 4'b0000;
        #1;
        chk("hold_drop_ready", 32'(rdy0), 32'h0);
        step();
        chk("hold_drop_tvalid", 32'(tv0), 32'h0);
        s_tvalid = 4'b1010;
        #1;
        chk("hold_next_p3_ready", 32'(rdy0), 32'h8);
        step();
        chk("hold_p3_tuser", 32'(tu0), 32'h3);
        chk("hold_p3_tdata", 32'(td0), 32'h4);
        #1;
        chk("hold_p3_burst_ready", 32'(rdy0), 32'h8);
        step();
        chk("hold_p3_beat2_tuser", 32'(tu0), 32'h3);
        #1;
        chk("hold_back_p1_ready", 32'(rdy0), 32'h2);
        step();
        chk("hold_back_p1_tuser", 32'(tu0), 32'h1);
        chk("hold_back_p1_tdata", 32'(td0), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
